free_list: RTL

Physical-register free list for the out-of-order rename stage. It feeds the RAT, supplying the next free physical register ID on every rename. It reclaims IDs that the retirement RAT releases when an instruction retires and overwrites an older mapping. Allocation is speculative and tracked separately from committed allocation, so a pipeline flush restores the list in one cycle (R10K-style circular list with speculative and commit heads).

---
 rtl/free_list.sv | 126 ++++++++++++
 1 files changed

// File: rtl/free_list.sv
`timescale 1ns/1ps
// free_list: physical-register free list for the rename stage.
// Circular buffer of free physical IDs with a speculative head (rename),
// a commit head (retirement) and a tail (RRAT recycling). A flush rewinds
// the speculative head to the commit head in a single cycle.
module free_list #(
    parameter int NUM_ARCH_REGS = 35,
    parameter int NUM_PHYS_REGS = 64,
    parameter int LOG_PHYS      = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_IN,
    output logic [LOG_PHYS-1:0] AllocID_OUT,
    output logic                AllocValid_OUT,
    input  logic                Commit_IN,
    input  logic                Free_IN,
    input  logic [LOG_PHYS-1:0] FreeID_IN,
    input  logic                Flush_IN,
    output logic [LOG_PHYS:0]   FreeCount_OUT,
    output logic                Error_OUT
);

    // Number of physical registers not mapped by the architectural state.
    localparam int NUM_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

    logic [LOG_PHYS-1:0] buffer [NUM_PHYS_REGS];

    logic [LOG_PHYS-1:0] spec_head;
    logic [LOG_PHYS-1:0] commit_head;
    logic [LOG_PHYS-1:0] tail;
    logic [LOG_PHYS:0]   spec_count;
    logic [LOG_PHYS:0]   pend_count;

    logic                commit_ok;
    logic                commit_err;
    logic                alloc_req;
    logic                alloc_ok;
    logic                alloc_err;
    logic                free_ok;
    logic                free_err;
    logic [LOG_PHYS+1:0] occupied;

    logic [LOG_PHYS-1:0] commit_head_next;
    logic [LOG_PHYS-1:0] spec_head_next;
    logic [LOG_PHYS:0]   pend_after_commit;
    logic [LOG_PHYS:0]   spec_count_next;
    logic [LOG_PHYS:0]   pend_count_next;

    // A flush takes priority over an allocation in the same cycle, and the
    // alloc is then silently dropped rather than flagged.
    assign alloc_req  = Alloc_IN && !Flush_IN;
    assign alloc_ok   = alloc_req && (spec_count != '0);
    assign alloc_err  = alloc_req && (spec_count == '0);

    assign commit_ok  = Commit_IN && (pend_count != '0);
    assign commit_err = Commit_IN && (pend_count == '0);

    // Every ID held between commitHead and tail is accounted for; once that
    // reaches the number of non-architectural registers the list is full.
    assign occupied   = {1'b0, spec_count} + {1'b0, pend_count};
    assign free_ok    = Free_IN && (occupied != (LOG_PHYS+2)'(NUM_FREE));
    assign free_err   = Free_IN && (occupied == (LOG_PHYS+2)'(NUM_FREE));

    assign commit_head_next  = commit_head + LOG_PHYS'(commit_ok);
    assign pend_after_commit = pend_count - (LOG_PHYS+1)'(commit_ok);

    // Next speculative head and counts; a flush folds the remaining pending
    // entries (after any same-cycle commit) back into the free pool.
    always_comb begin
        spec_head_next  = spec_head;
        spec_count_next = spec_count;
        pend_count_next = pend_count;
        if (Flush_IN) begin
            spec_head_next  = commit_head_next;
            spec_count_next = spec_count + pend_after_commit + (LOG_PHYS+1)'(free_ok);
            pend_count_next = '0;
        end else begin
            spec_head_next  = spec_head + LOG_PHYS'(alloc_ok);
            spec_count_next = spec_count - (LOG_PHYS+1)'(alloc_ok) + (LOG_PHYS+1)'(free_ok);
            pend_count_next = pend_after_commit + (LOG_PHYS+1)'(alloc_ok);
        end
    end

    // Buffer storage: preloaded with the unmapped IDs, written at tail on free.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < NUM_PHYS_REGS; k++) begin
                buffer[k] <= (k < NUM_FREE) ? LOG_PHYS'(NUM_ARCH_REGS + k) : '0;
            end
        end else if (free_ok) begin
            buffer[tail] <= FreeID_IN;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= LOG_PHYS'(NUM_FREE);
            spec_count  <= (LOG_PHYS+1)'(NUM_FREE);
            pend_count  <= '0;
        end else begin
            spec_head   <= spec_head_next;
            commit_head <= commit_head_next;
            tail        <= tail + LOG_PHYS'(free_ok);
            spec_count  <= spec_count_next;
            pend_count  <= pend_count_next;
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Error_OUT <= 1'b0;
        end else if (alloc_err || commit_err || free_err) begin
            Error_OUT <= 1'b1;
        end
    end

    assign AllocID_OUT    = buffer[spec_head];
    assign AllocValid_OUT = (spec_count != '0);
    assign FreeCount_OUT  = spec_count;

endmodule
